// File: rtl/stop_ctrl_pkg.sv
// Shared types and default constants for the stop/debounce front end.
package stop_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } deb_state_t;

    localparam int DEB_CYCLES_DEF    = 4;
    localparam int SYNC_STAGES_DEF   = 2;
    localparam int RESUME_CYCLES_DEF = 16;

endpackage

// File: rtl/stop_debounce_ctrl_sync.sv
// Generic flop-chain synchronizer for asynchronous board inputs.
module btn_sync
    import stop_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic synced
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], level};
        end
    end

    assign synced = chain[SYNC_STAGES-1];

endmodule

// File: rtl/stop_debounce_ctrl.sv
// Button synchronizer, debounce FSM and Stop generation (hold or toggle mode).
// Optional build macro AUTO_RESUME_EN: toggle-mode Stop self-clears after RESUME_CYCLES.
module stop_debounce_ctrl
    import stop_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int RESUME_CYCLES = RESUME_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic mode,
    output logic Stop,
    output logic btn_clean,
    output logic btn_pulse
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES);

    if (DEB_CYCLES < 1 || SYNC_STAGES < 2 || RESUME_CYCLES < 1) begin : g_param_check
        $error("stop_debounce_ctrl: illegal parameter value");
    end

    logic             sync_btn;
    deb_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             press_acc, release_acc;
    logic             toggle_reg;

    btn_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .level (btn_raw),
        .synced(sync_btn)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        press_acc   = 1'b0;
        release_acc = 1'b0;
        unique case (state)
            IDLE: begin
                if (sync_btn) begin
                    if (DEB_CYCLES == 1) begin
                        state_next = PRESSED;
                        press_acc  = 1'b1;
                    end else begin
                        state_next = PRESS_WAIT;
                        cnt_next   = CNT_W'(1);
                    end
                end
            end
            PRESS_WAIT: begin
                if (!sync_btn) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt + 1'b1 == DEB_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    press_acc  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync_btn) begin
                    if (DEB_CYCLES == 1) begin
                        state_next  = IDLE;
                        release_acc = 1'b1;
                    end else begin
                        state_next = RELEASE_WAIT;
                        cnt_next   = CNT_W'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                if (sync_btn) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt + 1'b1 == DEB_LAST) begin
                    state_next  = IDLE;
                    cnt_next    = '0;
                    release_acc = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_clean <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            btn_pulse <= press_acc;
            if (press_acc) begin
                btn_clean <= 1'b1;
            end else if (release_acc) begin
                btn_clean <= 1'b0;
            end
        end
    end

`ifdef AUTO_RESUME_EN
    localparam int TMR_W = $clog2(RESUME_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RESUME_CYCLES - 1);

    logic [TMR_W-1:0] resume_tmr;
    logic             timeout;

    assign timeout = mode && toggle_reg && (resume_tmr == TMR_LAST);

    // A press landing on the timeout edge must leave Stop released, not flip it twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_reg <= 1'b0;
            resume_tmr <= '0;
        end else begin
            if (press_acc) begin
                toggle_reg <= timeout ? 1'b0 : ~toggle_reg;
            end else if (timeout) begin
                toggle_reg <= 1'b0;
            end
            if (press_acc || timeout || !mode || !toggle_reg) begin
                resume_tmr <= '0;
            end else begin
                resume_tmr <= resume_tmr + 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_reg <= 1'b0;
        end else if (press_acc) begin
            toggle_reg <= ~toggle_reg;
        end
    end
`endif

    always_comb begin
        Stop = mode ? toggle_reg : btn_clean;
    end

endmodule

// File: tb/tb_stop_debounce_ctrl.sv
// Self-checking bench for stop_debounce_ctrl: directed scenarios plus random button traffic vs. a sample-window model.
module tb_stop_debounce_ctrl;
    import stop_ctrl_pkg::*;

    localparam int DEB = DEB_CYCLES_DEF;
    localparam int SYN = SYNC_STAGES_DEF;
    localparam int RES = RESUME_CYCLES_DEF;
    localparam int LAT = SYN - 1 + DEB;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic mode;
    logic Stop;
    logic btn_clean;
    logic btn_pulse;

    int errors = 0;
    int checks = 0;

    // Reference state: raw samples newest-first, accepted level, pulse, toggle, resume timer.
    bit hist[$];
    bit m_clean, m_pulse, m_tog;
    int m_tcnt;

    always #5 clk = ~clk;

    stop_debounce_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .mode     (mode),
        .Stop     (Stop),
        .btn_clean(btn_clean),
        .btn_pulse(btn_pulse)
    );

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SYN + DEB; i++) hist.push_back(1'b0);
        m_clean = 1'b0;
        m_pulse = 1'b0;
        m_tog   = 1'b0;
        m_tcnt  = 0;
    endtask

    // A level is accepted once the DEB samples that have cleared the synchronizer all disagree with it.
    task automatic model_edge();
        bit acc, press;
        hist.push_front(btn_raw);
        void'(hist.pop_back());
        acc = 1'b1;
        for (int i = SYN; i < SYN + DEB; i++) if (hist[i] == m_clean) acc = 1'b0;
        press = acc && !m_clean;
`ifdef AUTO_RESUME_EN
        begin
            bit timeout;
            timeout = mode && m_tog && (m_tcnt + 1 == RES);
            if (press || timeout) begin
                m_tog  = (press && !timeout) ? !m_tog : 1'b0;
                m_tcnt = 0;
            end else if (mode && m_tog) begin
                m_tcnt++;
            end else begin
                m_tcnt = 0;
            end
        end
`else
        if (press) m_tog = !m_tog;
`endif
        if (acc) m_clean = !m_clean;
        m_pulse = press;
    endtask

    function automatic logic [2:0] model_out();
        return {(mode ? m_tog : m_clean), m_clean, m_pulse};
    endfunction

    task automatic step(input logic b, input logic m);
        btn_raw = b;
        mode    = m;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int rise;
        rst = 1'b1; btn_raw = 1'b1; mode = 1'b0;
        #2;
        checks++;
        if ({Stop, btn_clean, btn_pulse} !== 3'b000) begin
            errors++; $display("FAIL reset_early: got %b want 000", {Stop, btn_clean, btn_pulse});
        end
        #6;
        checks++;
        if ({Stop, btn_clean, btn_pulse} !== 3'b000) begin
            errors++; $display("FAIL reset_held: got %b want 000", {Stop, btn_clean, btn_pulse});
        end
        #4;
        rst = 1'b0;
        model_reset();
        rise = -1;
        for (int n = 0; n < 12; n++) begin
            step(1'b1, 1'b0);
            checks++;
            if ({Stop, btn_clean, btn_pulse} !== model_out()) begin
                errors++; $display("FAIL reset_rise_model n=%0d: got %b want %b", n, {Stop, btn_clean, btn_pulse}, model_out());
            end
            if (rise < 0 && btn_clean === 1'b1) rise = n;
        end
        checks++;
        if (rise !== LAT) begin
            errors++; $display("FAIL reset_latency: got %0d want %0d", rise, LAT);
        end
        for (int n = 0; n < 8; n++) step(1'b0, 1'b0);
    endtask

    task automatic test_clean_press();
        int rise, fall, pulses;
        apply_reset();
        for (int n = 0; n < 3; n++) step(1'b0, 1'b0);
        rise = -1; fall = -1; pulses = 0;
        for (int n = 0; n < 10; n++) begin
            step(1'b1, 1'b0);
            checks++;
            if ({Stop, btn_clean, btn_pulse} !== model_out()) begin
                errors++; $display("FAIL press_model n=%0d: got %b want %b", n, {Stop, btn_clean, btn_pulse}, model_out());
            end
            if (rise < 0 && Stop === 1'b1) rise = n;
            if (btn_pulse === 1'b1) pulses++;
        end
        for (int n = 0; n < 10; n++) begin
            step(1'b0, 1'b0);
            checks++;
            if ({Stop, btn_clean, btn_pulse} !== model_out()) begin
                errors++; $display("FAIL release_model n=%0d: got %b want %b", n, {Stop, btn_clean, btn_pulse}, model_out());
            end
            if (fall < 0 && Stop === 1'b0) fall = n;
            if (btn_pulse === 1'b1) pulses++;
        end
        checks++;
        if (rise !== LAT) begin
            errors++; $display("FAIL press_latency: got %0d want %0d", rise, LAT);
        end
        checks++;
        if (fall !== LAT) begin
            errors++; $display("FAIL release_latency: got %0d want %0d", fall, LAT);
        end
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL press_pulse_count: got %0d want 1", pulses);
        end
    endtask

    task automatic test_bounce();
        logic [13:0] pat;
        apply_reset();
        pat = 14'b11101100000000;
        for (int n = 13; n >= 0; n--) begin
            step(pat[n], 1'b0);
            checks++;
            if ({Stop, btn_clean, btn_pulse} !== 3'b000) begin
                errors++; $display("FAIL bounce n=%0d: got %b want 000", 13 - n, {Stop, btn_clean, btn_pulse});
            end
        end
    endtask

    task automatic test_toggle();
        int pulses;
        logic stop_mid;
        apply_reset();
        pulses = 0;
        for (int p = 0; p < 2; p++) begin
            for (int n = 0; n < 14; n++) begin
                step(n < 8, 1'b1);
                checks++;
                if ({Stop, btn_clean, btn_pulse} !== model_out()) begin
                    errors++; $display("FAIL toggle_model p=%0d n=%0d: got %b want %b", p, n, {Stop, btn_clean, btn_pulse}, model_out());
                end
                if (btn_pulse === 1'b1) pulses++;
            end
            if (p == 0) stop_mid = Stop;
        end
        checks++;
        if (stop_mid !== 1'b1) begin
            errors++; $display("FAIL toggle_first: got %b want 1", stop_mid);
        end
        checks++;
        if (Stop !== 1'b0) begin
            errors++; $display("FAIL toggle_second: got %b want 0", Stop);
        end
        checks++;
        if (pulses !== 2) begin
            errors++; $display("FAIL toggle_pulse_count: got %0d want 2", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int rise;
        apply_reset();
        for (int n = 0; n < 14; n++) step(n < 8, 1'b1);
        checks++;
        if (Stop !== 1'b1) begin
            errors++; $display("FAIL midrst_setup: got %b want 1", Stop);
        end
        for (int n = 0; n < 4; n++) step(1'b1, 1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if ({Stop, btn_clean, btn_pulse} !== 3'b000) begin
            errors++; $display("FAIL midrst_immediate: got %b want 000", {Stop, btn_clean, btn_pulse});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        rise = -1;
        for (int n = 0; n < 10; n++) begin
            step(1'b1, 1'b1);
            checks++;
            if ({Stop, btn_clean, btn_pulse} !== model_out()) begin
                errors++; $display("FAIL midrst_model n=%0d: got %b want %b", n, {Stop, btn_clean, btn_pulse}, model_out());
            end
            if (rise < 0 && btn_clean === 1'b1) rise = n;
        end
        checks++;
        if (rise !== LAT) begin
            errors++; $display("FAIL midrst_latency: got %0d want %0d", rise, LAT);
        end
        for (int n = 0; n < 8; n++) step(1'b0, 1'b1);
    endtask

    task automatic test_auto_resume();
        int rise, fall, high_cnt;
        apply_reset();
        rise = -1; fall = -1; high_cnt = 0;
        for (int n = 0; n < 110; n++) begin
            step(n < 8, 1'b1);
            checks++;
            if ({Stop, btn_clean, btn_pulse} !== model_out()) begin
                errors++; $display("FAIL resume_model n=%0d: got %b want %b", n, {Stop, btn_clean, btn_pulse}, model_out());
            end
            if (rise < 0 && Stop === 1'b1) rise = n;
            else if (rise >= 0 && fall < 0 && Stop === 1'b0) fall = n;
            if (Stop === 1'b1) high_cnt++;
        end
`ifdef AUTO_RESUME_EN
        checks++;
        if (fall - rise !== RES) begin
            errors++; $display("FAIL resume_timeout: got %0d want %0d", fall - rise, RES);
        end
`else
        checks++;
        if (fall !== -1 || high_cnt < 100) begin
            errors++; $display("FAIL resume_hold: got fall=%0d high=%0d want fall=-1 high>=100", fall, high_cnt);
        end
`endif
    endtask

    task automatic test_random();
        logic b, m;
        int len, n;
        apply_reset();
        b = 1'b0; m = 1'b0; n = 0;
        while (n < 900) begin
            b = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) m = ~m;
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                step(b, m);
                n++;
                checks++;
                if ({Stop, btn_clean, btn_pulse} !== model_out()) begin
                    errors++; $display("FAIL random n=%0d: got %b want %b", n, {Stop, btn_clean, btn_pulse}, model_out());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_toggle();
        test_reset_mid();
        test_auto_resume();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
